// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin, packet-lockable arbiter sharing one UART TX core
//               between two byte requesters, with a frame-timeout watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_tx_arbiter #(
  parameter int CLK_RATE       = 100*10**6,
  parameter int BAUD_RATE      = 115200,
  parameter int TIMEOUT_FRAMES = 2,
  parameter int MAX_BURST      = 16
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic [1:0] REQ_I,
  input  logic [1:0] LOCK_I,
  input  logic [7:0] DATA0_I,
  input  logic [7:0] DATA1_I,
  output logic [1:0] GNT_O,
  output logic       TX_START_O,
  output logic [7:0] TX_DATA_O,
  input  logic       TX_DONE_I,
  output logic       BUSY_O,
  output logic       OWNER_O,
  output logic       ERR_O,
  input  logic       CLR_ERR_I
);

  localparam int c_BIT_CYC  = CLK_RATE / BAUD_RATE;
  localparam int c_WD_LIMIT = TIMEOUT_FRAMES * 10 * c_BIT_CYC;
  localparam int c_WD_W     = (c_WD_LIMIT > 2) ? $clog2(c_WD_LIMIT) : 1;
  localparam int c_BURST_W  = $clog2(MAX_BURST + 1);

  localparam logic [c_WD_W-1:0]    c_WD_LAST   = c_WD_W'(c_WD_LIMIT - 1);
  localparam logic [c_BURST_W-1:0] c_MAX_BURST = c_BURST_W'(MAX_BURST);
  localparam logic [c_BURST_W-1:0] c_BURST_ONE = c_BURST_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_BURST_W-1:0]  r_burst;
  logic [c_WD_W-1:0]     r_wdog;

  logic                  w_win;
  logic                  w_cont;
  logic [c_BURST_W-1:0]  w_burst_inc;

  // Lone requester wins; on contention the port not served last wins.
  always_comb begin
    w_win = ~OWNER_O;
    if (REQ_I == 2'b01)
      w_win = 1'b0;
    else if (REQ_I == 2'b10)
      w_win = 1'b1;
    w_cont      = LOCK_I[OWNER_O] & REQ_I[OWNER_O] & (r_burst < c_MAX_BURST);
    w_burst_inc = (r_burst < c_MAX_BURST) ? r_burst + c_BURST_ONE : r_burst;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_state    <= S_IDLE;
      r_burst    <= '0;
      r_wdog     <= '0;
      GNT_O      <= 2'b00;
      TX_START_O <= 1'b0;
      TX_DATA_O  <= 8'h00;
      BUSY_O     <= 1'b0;
      OWNER_O    <= 1'b1;
      ERR_O      <= 1'b0;
    end else begin
      GNT_O      <= 2'b00;
      TX_START_O <= 1'b0;
      if (CLR_ERR_I)
        ERR_O <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (|REQ_I) begin
            r_state    <= S_SEND;
            TX_DATA_O  <= w_win ? DATA1_I : DATA0_I;
            TX_START_O <= 1'b1;
            GNT_O      <= {w_win, ~w_win};
            OWNER_O    <= w_win;
            BUSY_O     <= 1'b1;
            r_burst    <= (w_win != OWNER_O) ? c_BURST_ONE : w_burst_inc;
          end
        end

        S_SEND: begin
          r_wdog  <= '0;
          r_state <= S_WAIT;
        end

        S_WAIT: begin
          // Done beats a same-cycle timeout, so it is tested first.
          if (TX_DONE_I) begin
            if (w_cont) begin
              r_state    <= S_SEND;
              TX_DATA_O  <= OWNER_O ? DATA1_I : DATA0_I;
              TX_START_O <= 1'b1;
              GNT_O      <= {OWNER_O, ~OWNER_O};
              r_burst    <= r_burst + c_BURST_ONE;
            end else begin
              r_state <= S_IDLE;
              BUSY_O  <= 1'b0;
            end
          end else if (r_wdog == c_WD_LAST) begin
            ERR_O   <= 1'b1;
            r_state <= S_IDLE;
            BUSY_O  <= 1'b0;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          BUSY_O  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Scoreboard bench for uart_tx_arbiter at default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx_arbiter;

  localparam int c_BIT_CYC = 100000000 / 115200;   // 868
  localparam int c_LIMIT   = 2 * 10 * c_BIT_CYC;   // 17360
  localparam int c_FRAME   = 10 * c_BIT_CYC;       // 8680

  logic       CLK_I = 1'b0;
  logic       RST_I = 1'b1;
  logic [1:0] REQ_I = 2'b00;
  logic [1:0] LOCK_I = 2'b00;
  logic [7:0] DATA0_I = 8'h00;
  logic [7:0] DATA1_I = 8'h00;
  logic       TX_DONE_I = 1'b0;
  logic       CLR_ERR_I = 1'b0;
  logic [1:0] GNT_O;
  logic       TX_START_O;
  logic [7:0] TX_DATA_O;
  logic       BUSY_O;
  logic       OWNER_O;
  logic       ERR_O;

  int checks  = 0;
  int errors  = 0;
  int n_start = 0;
  int done_dly = 3;
  logic wd_pulse = 1'b0;

  logic [8:0] exp_q[$];   // {port, byte} expected at each TX_START_O
  logic [7:0] src0[$];
  logic [7:0] src1[$];

  uart_tx_arbiter dut (
    .CLK_I      (CLK_I),
    .RST_I      (RST_I),
    .REQ_I      (REQ_I),
    .LOCK_I     (LOCK_I),
    .DATA0_I    (DATA0_I),
    .DATA1_I    (DATA1_I),
    .GNT_O      (GNT_O),
    .TX_START_O (TX_START_O),
    .TX_DATA_O  (TX_DATA_O),
    .TX_DONE_I  (TX_DONE_I),
    .BUSY_O     (BUSY_O),
    .OWNER_O    (OWNER_O),
    .ERR_O      (ERR_O),
    .CLR_ERR_I  (CLR_ERR_I)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Requesters: hold REQ/DATA until the byte is granted, then present the next one.
  initial forever begin
    @(negedge CLK_I);
    if (GNT_O[0] && src0.size() > 0) void'(src0.pop_front());
    if (GNT_O[1] && src1.size() > 0) void'(src1.pop_front());
    REQ_I[0] = (src0.size() > 0);
    DATA0_I  = (src0.size() > 0) ? src0[0] : 8'h00;
    REQ_I[1] = (src1.size() > 0) | wd_pulse;
    DATA1_I  = (src1.size() > 0) ? src1[0] : 8'hEE;
  end

  // TX core model: done pulse done_dly cycles after the start cycle (0 = never).
  initial begin
    bit aborted;
    @(negedge CLK_I);
    forever begin
      if (TX_START_O && !RST_I && done_dly != 0) begin
        aborted = 1'b0;
        for (int k = 0; k < done_dly; k++) begin
          @(negedge CLK_I);
          if (RST_I) aborted = 1'b1;
        end
        if (!aborted) begin
          TX_DONE_I = 1'b1;
          @(negedge CLK_I);
          TX_DONE_I = 1'b0;
        end
      end else begin
        @(negedge CLK_I);
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge CLK_I);
      if (!RST_I) begin
        if (TX_START_O) begin
          n_start++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_start actual=%0h required=none", {GNT_O, TX_DATA_O});
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", {GNT_O, TX_DATA_O}, {(e[8] ? 2'b10 : 2'b01), e[7:0]});
          end
        end else if (GNT_O != 2'b00) begin
          check("gnt_without_start", {30'd0, GNT_O}, 32'd0);
        end
      end
    end
  end

  task automatic do_reset();
    RST_I     = 1'b1;
    src0.delete();
    src1.delete();
    exp_q.delete();
    LOCK_I    = 2'b00;
    wd_pulse  = 1'b0;
    CLR_ERR_I = 1'b0;
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b0;
  endtask

  task automatic wait_start(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge CLK_I);
      n++;
    end while (!TX_START_O && n < budget);
    check(name, {31'd0, TX_START_O}, 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || src0.size() != 0 || src1.size() != 0 || BUSY_O) && n < budget) begin
      @(negedge CLK_I);
      n++;
    end
    check(name, (n < budget) ? exp_q.size() : 32'hFFFF_FFFF, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int s;
    repeat (3) @(negedge CLK_I);
    RST_I = 1'b0;
    check("reset_outputs", {GNT_O, TX_START_O, TX_DATA_O, BUSY_O, OWNER_O, ERR_O},
          {2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});

    // T2: single byte, one-cycle latency, full-length frame.
    done_dly = c_FRAME;
    exp_q.push_back({1'b0, 8'hA5});
    src0.push_back(8'hA5);
    s = 0;
    do begin
      @(posedge CLK_I);
      s++;
    end while (!REQ_I[0] && s < 10);
    @(negedge CLK_I);
    check("t2_start_latency", {31'd0, TX_START_O}, 32'd1);
    repeat (c_FRAME) @(negedge CLK_I);
    check("t2_busy_during_frame", {31'd0, BUSY_O}, 32'd1);
    @(negedge CLK_I);
    check("t2_idle_after_done", {BUSY_O, ERR_O, OWNER_O}, 3'b000);

    // T3: unlocked round robin with both ports requesting.
    do_reset();
    done_dly = 3;
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    src0.push_back(8'h11); src0.push_back(8'h11);
    src1.push_back(8'h22); src1.push_back(8'h22);
    wait_idle("t3_rr_drain", 500);

    // T4: locked port 0 bursts 16 bytes, then port 1 gets one, then port 0 resumes.
    do_reset();
    done_dly = 3;
    LOCK_I   = 2'b01;
    for (int i = 0; i < 20; i++) src0.push_back(8'h40 + 8'(i));
    src1.push_back(8'hBB);
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b0, 8'h40 + 8'(i)});
    exp_q.push_back({1'b1, 8'hBB});
    for (int i = 16; i < 20; i++) exp_q.push_back({1'b0, 8'h40 + 8'(i)});
    wait_idle("t4_lock_drain", 2000);
    LOCK_I = 2'b00;

    // T5: watchdog timeout, clear, and done on the exact timeout cycle.
    do_reset();
    done_dly = 0;
    exp_q.push_back({1'b0, 8'hC3});
    src0.push_back(8'hC3);
    wait_start("t5_start", 20);
    repeat (c_LIMIT) @(negedge CLK_I);
    check("t5_before_timeout", {ERR_O, BUSY_O}, 2'b01);
    @(negedge CLK_I);
    check("t5_timeout", {ERR_O, BUSY_O}, 2'b10);
    CLR_ERR_I = 1'b1;
    @(negedge CLK_I);
    CLR_ERR_I = 1'b0;
    check("t5_err_cleared", {31'd0, ERR_O}, 32'd0);
    done_dly = c_LIMIT;
    exp_q.push_back({1'b0, 8'hC4});
    src0.push_back(8'hC4);
    wait_start("t5_start2", 20);
    repeat (c_LIMIT + 1) @(negedge CLK_I);
    check("t5_done_beats_timeout", {ERR_O, BUSY_O}, 2'b00);

    // T6: one-cycle withdrawn request on port 1 while port 0 is busy.
    do_reset();
    done_dly = 20;
    exp_q.push_back({1'b0, 8'h5A});
    src0.push_back(8'h5A);
    s = n_start;
    wait_start("t6_start", 20);
    repeat (5) @(negedge CLK_I);
    @(posedge CLK_I); #1 wd_pulse = 1'b1;
    @(posedge CLK_I); #1 wd_pulse = 1'b0;
    wait_idle("t6_drain", 200);
    repeat (10) @(negedge CLK_I);
    check("t6_single_frame", n_start - s, 32'd1);

    // T1: reset in the middle of WAIT.
    do_reset();
    done_dly = 0;
    exp_q.push_back({1'b0, 8'h5A});
    src0.push_back(8'h5A);
    wait_start("t1_start", 20);
    repeat (5) @(negedge CLK_I);
    #2 RST_I = 1'b1;
    #1 check("t1_async_reset", {GNT_O, TX_START_O, TX_DATA_O, BUSY_O, OWNER_O, ERR_O},
             {2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0});
    src0.delete();
    exp_q.delete();
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b0;
    s = n_start;
    repeat (40) @(negedge CLK_I);
    check("t1_no_start_after_reset", n_start - s, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
